// File: rtl/dmux_stream_pkg.sv
// Shared types for the N-way valid/ready stream demultiplexer.
package dmux_stream_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} dmux_state_t;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/dmux_stream_slot.sv
// One-entry output register slot: holds data/last/valid, loads from the router
// and drains to its consumer independently of the other slots.
module dmux_stream_slot
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             can_load,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // A load in the same cycle as a drain wins, so the slot stays full with new data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
endmodule

// File: rtl/dmux_n_way_stream.sv
// Packet-locked 1-to-CHANNELS stream demultiplexer with registered outputs.
// Optional drop counter enabled by defining DMUX_N_WAY_STREAM_DROP_CNT_EN.
module dmux_n_way_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_select,
  input  logic                      in_last,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_last
`ifdef DMUX_N_WAY_STREAM_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_count
`endif
);
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  dmux_state_t         state_q, state_d;
  logic [SEL_W-1:0]    route_q, route_d, eff_route;
  logic                route_bad_q, route_bad_d, eff_bad, sel_bad, accept;
  logic [CHANNELS-1:0] slot_can_load, slot_load;

  // The select is only meaningful on the first beat; mid-packet the latched route rules.
  assign sel_bad   = ({1'b0, in_select} >= CH_LIMIT);
  assign eff_route = (state_q == IDLE) ? in_select : route_q;
  assign eff_bad   = (state_q == IDLE) ? sel_bad : route_bad_q;
  assign in_ready  = eff_bad | slot_can_load[eff_route];
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    route_bad_d = route_bad_q;
    if (accept) begin
      if (state_q == IDLE) begin
        route_d     = in_select;
        route_bad_d = sel_bad;
        if (!in_last) state_d = BURST;
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      route_q     <= '0;
      route_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      route_bad_q <= route_bad_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
    assign slot_load[gi] = accept && !eff_bad && (eff_route == SEL_W'(gi));

    dmux_stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[gi]),
      .load_data (in_data),
      .load_last (in_last),
      .can_load  (slot_can_load[gi]),
      .out_ready (out_ready[gi]),
      .out_valid (out_valid[gi]),
      .out_data  (out_data[gi*WIDTH +: WIDTH]),
      .out_last  (out_last[gi])
    );
  end

`ifdef DMUX_N_WAY_STREAM_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && eff_bad && (drop_q != {DROP_CNT_W{1'b1}})) drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif
endmodule
